// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared state type, pattern limits and mask helpers for the pattern scanner
package pattern_scan_pkg;

  localparam int MAX_PAT_LEN = 4;
  localparam int PAT_LEN_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Lengths outside 1..MAX_PAT_LEN get an empty mask and never match.
  function automatic logic [MAX_PAT_LEN-1:0] pat_mask(input logic [PAT_LEN_W-1:0] len);
    case (len)
      3'd1:    pat_mask = 4'b0001;
      3'd2:    pat_mask = 4'b0011;
      3'd3:    pat_mask = 4'b0111;
      3'd4:    pat_mask = 4'b1111;
      default: pat_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic pat_len_ok(input logic [PAT_LEN_W-1:0] len);
    return (len != '0) && (len <= 3'(MAX_PAT_LEN));
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// rtl/pattern_scan_ctrl_if.sv - requester/result bus between the sources and pattern_scan_ctrl
interface pattern_scan_ctrl_if
  import pattern_scan_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]           req;
  logic [N*DATA_W-1:0]    req_data;
  logic [MAX_PAT_LEN-1:0] pat;
  logic [PAT_LEN_W-1:0]   pat_len;
  logic [N-1:0]           gnt;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       match_cnt;

  modport master (
    output req, req_data, pat, pat_len,
    input  gnt, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, req_data, pat, pat_len,
    output gnt, busy, done, done_id, match_cnt
  );

endinterface

// File: rtl/pattern_detect_core.sv
// rtl/pattern_detect_core.sv - serial window/fill detector; PATTERN_SCAN_OVERLAP_EN keeps the window after a match
module pattern_detect_core
  import pattern_scan_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   bit_vld,
  input  logic                   bit_in,
  input  logic [MAX_PAT_LEN-1:0] pat,
  input  logic [PAT_LEN_W-1:0]   pat_len,
  output logic                   match
);

  logic [MAX_PAT_LEN-2:0] r_hist;
  logic [PAT_LEN_W-1:0]   r_fill;
  logic [MAX_PAT_LEN-1:0] w_win_nxt;
  logic [PAT_LEN_W-1:0]   w_fill_nxt;
  logic                   w_match;

  // The compare looks at the window including the bit arriving this cycle.
  always_comb begin
    w_win_nxt  = {r_hist, bit_in};
    w_fill_nxt = (r_fill >= PAT_LEN_W'(MAX_PAT_LEN)) ? PAT_LEN_W'(MAX_PAT_LEN)
                                                     : r_fill + PAT_LEN_W'(1);
    w_match    = bit_vld && pat_len_ok(pat_len) && (w_fill_nxt >= pat_len) &&
                 (((w_win_nxt ^ pat) & pat_mask(pat_len)) == '0);
  end

  assign match = w_match;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (bit_vld) begin
      r_hist <= w_win_nxt[MAX_PAT_LEN-2:0];
`ifdef PATTERN_SCAN_OVERLAP_EN
      r_fill <= w_fill_nxt;
`else
      r_fill <= w_match ? '0 : w_fill_nxt;
`endif
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - round-robin scheduler feeding granted words MSB-first into one shared detector
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
)(
  input  logic               clk,
  input  logic               rst,
  pattern_scan_ctrl_if.slave bus
);

  localparam int ID_W = $clog2(N);
  localparam int BC_W = $clog2(DATA_W);

  scan_state_t            r_state;
  scan_state_t            w_state_nxt;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_done_id;
  logic [DATA_W-1:0]      r_shift;
  logic [MAX_PAT_LEN-1:0] r_pat;
  logic [PAT_LEN_W-1:0]   r_pat_len;
  logic [BC_W-1:0]        r_bit_cnt;
  logic [CNT_W-1:0]       r_match_cnt;

  logic [ID_W-1:0]        w_arb_idx;
  logic [ID_W-1:0]        w_rr_nxt;
  logic                   w_arb_hit;
  logic [DATA_W-1:0]      w_sel_data;
  logic [N-1:0]           w_gnt;
  logic                   w_grant;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_scan;
  logic                   w_match;

  // Lowest requester overall is the wrap fallback; lowest at/above rr_ptr overrides it.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = ID_W'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_arb_idx = ID_W'(i);
      end
    end
    w_rr_nxt = (w_arb_idx == ID_W'(N - 1)) ? '0 : w_arb_idx + ID_W'(1);
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_arb_idx == ID_W'(i)) begin
        w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt       = '0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_scan      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst && w_arb_hit) begin
          w_grant          = 1'b1;
          w_gnt[w_arb_idx] = 1'b1;
          w_busy           = 1'b1;
          w_state_nxt      = SCAN;
        end
      end
      SCAN: begin
        w_busy = 1'b1;
        w_scan = 1'b1;
        if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request word and pattern are frozen at grant so later input changes cannot disturb the scan.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_done_id   <= '0;
      r_shift     <= '0;
      r_pat       <= '0;
      r_pat_len   <= '0;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
    end else if (w_grant) begin
      r_rr_ptr    <= w_rr_nxt;
      r_done_id   <= w_arb_idx;
      r_shift     <= w_sel_data;
      r_pat       <= bus.pat;
      r_pat_len   <= bus.pat_len;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
    end else if (w_scan) begin
      r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + BC_W'(1);
      if (w_match) begin
        r_match_cnt <= r_match_cnt + CNT_W'(1);
      end
    end
  end

  pattern_detect_core u_detect (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_grant),
    .bit_vld (w_scan),
    .bit_in  (r_shift[DATA_W-1]),
    .pat     (r_pat),
    .pat_len (r_pat_len),
    .match   (w_match)
  );

  assign bus.gnt       = w_gnt;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.done_id   = r_done_id;
  assign bus.match_cnt = r_match_cnt;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - directed vector bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

  localparam int N      = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;
`ifdef PATTERN_SCAN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  pattern_scan_ctrl_if #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  pattern_scan_ctrl #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0]        req;
    logic [N*DATA_W-1:0] data;
    logic [3:0]          pat;
    logic [2:0]          len;
    int                  exp_id;
    int                  cnt_no;
    int                  cnt_ov;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k);
    int c;
    int exp_cnt;
    exp_cnt = OVL ? vecs[k].cnt_ov : vecs[k].cnt_no;
    @(negedge clk);
    bus.req      = vecs[k].req;
    bus.req_data = vecs[k].data;
    bus.pat      = vecs[k].pat;
    bus.pat_len  = vecs[k].len;
    #1;
    c = 0;
    while (bus.gnt == '0 && c < 40) begin
      @(negedge clk); #1; c++;
    end
    chk($sformatf("v%0d_gnt", k), 64'(bus.gnt), 64'(1 << vecs[k].exp_id));
    chk($sformatf("v%0d_busy_at_gnt", k), 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.req      = '0;
    bus.req_data = ~bus.req_data;
    bus.pat      = ~bus.pat;
    bus.pat_len  = bus.pat_len + 3'd1;
    #1;
    c = 1;
    while (!bus.done && c < 40) begin
      @(negedge clk); #1; c++;
    end
    chk($sformatf("v%0d_done_latency", k), 64'(c), 64'd17);
    chk($sformatf("v%0d_done_id", k), 64'(bus.done_id), 64'(vecs[k].exp_id));
    chk($sformatf("v%0d_match_cnt", k), 64'(bus.match_cnt), 64'(exp_cnt));
    @(negedge clk); #1;
    chk($sformatf("v%0d_done_pulse_end", k), 64'(bus.done), 64'd0);
    chk($sformatf("v%0d_busy_end", k), 64'(bus.busy), 64'd0);
    chk($sformatf("v%0d_cnt_hold", k), 64'(bus.match_cnt), 64'(exp_cnt));
  endtask

  initial begin
    int c;
    int last;
    bit seen_done;

    vecs[0]  = '{4'b0001, 64'h0000_0000_0000_5000, 4'b0010, 3'd3, 0, 1, 2};
    vecs[1]  = '{4'b0001, 64'h0000_0000_0000_FFFF, 4'b0001, 3'd1, 0, 16, 16};
    vecs[2]  = '{4'b0001, 64'h0000_0000_0000_5000, 4'b0010, 3'd0, 0, 0, 0};
    vecs[3]  = '{4'b0110, 64'h0000_0000_AAAA_0000, 4'b1010, 3'd4, 1, 4, 7};
    vecs[4]  = '{4'b0110, 64'h0000_0000_FFFF_0000, 4'b0000, 3'd4, 2, 4, 13};
    vecs[5]  = '{4'b0011, 64'h0000_0000_FFFF_8001, 4'b0001, 3'd1, 0, 2, 2};
    vecs[6]  = '{4'b1000, 64'hF00F_0000_0000_0000, 4'b0011, 3'd2, 3, 4, 6};
    vecs[7]  = '{4'b0100, 64'h0000_FFFF_0000_0000, 4'b1111, 3'd5, 2, 0, 0};
    vecs[8]  = '{4'b0001, 64'h0000_0000_0000_5000, 4'b1010, 3'd3, 0, 1, 2};
    vecs[9]  = '{4'b0010, 64'h0000_0000_8000_0000, 4'b0001, 3'd2, 1, 0, 0};
    vecs[10] = '{4'b0010, 64'h0000_0000_8000_0000, 4'b0010, 3'd2, 1, 1, 1};

    bus.req      = 4'b1111;
    bus.req_data = '0;
    bus.pat      = '0;
    bus.pat_len  = 3'd1;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_done_id", 64'(bus.done_id), 64'd0);
    chk("rst_match_cnt", 64'(bus.match_cnt), 64'd0);
    @(negedge clk);
    bus.req = '0;
    rst     = 1'b1;

    for (int k = 0; k < 11; k++) begin
      run_vec(k);
    end

    // Round robin with all requests held from reset.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst          = 1'b1;
    bus.req      = 4'b1111;
    bus.req_data = '0;
    bus.pat      = 4'b0000;
    bus.pat_len  = 3'd1;
    #1;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      c = 0;
      while (bus.gnt == '0 && c < 40) begin
        @(negedge clk); #1; c++;
      end
      chk($sformatf("rr%0d_gnt", g), 64'(bus.gnt), 64'(1 << (g % 4)));
      if (g > 0) chk($sformatf("rr%0d_spacing", g), 64'(cyc - last), 64'd18);
      last = cyc;
      c = 0;
      do begin
        @(negedge clk); #1; c++;
      end while (!bus.done && c < 40);
      chk($sformatf("rr%0d_done_id", g), 64'(bus.done_id), 64'(g % 4));
      chk($sformatf("rr%0d_match_cnt", g), 64'(bus.match_cnt), 64'd16);
    end
    bus.req = '0;

    // Reset five cycles into a scan: everything clears, no strobe, pointer back to 0.
    @(negedge clk);
    @(negedge clk);
    bus.req      = 4'b0010;
    bus.req_data = 64'h0000_0000_FFFF_0000;
    bus.pat      = 4'b0001;
    bus.pat_len  = 3'd1;
    #1;
    chk("mid_gnt", 64'(bus.gnt), 64'b0010);
    repeat (5) @(negedge clk);
    rst     = 1'b0;
    bus.req = '0;
    @(negedge clk); #1;
    chk("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_done_id", 64'(bus.done_id), 64'd0);
    chk("mid_rst_match_cnt", 64'(bus.match_cnt), 64'd0);
    rst       = 1'b1;
    seen_done = 1'b0;
    repeat (25) begin
      @(negedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    chk("mid_rst_no_done", 64'(seen_done), 64'd0);
    @(negedge clk);
    bus.req = 4'b1111;
    #1;
    chk("post_rst_gnt", 64'(bus.gnt), 64'b0001);
    @(negedge clk);
    bus.req = '0;
    c = 0;
    while (!bus.done && c < 40) begin
      @(negedge clk); #1; c++;
    end
    chk("post_rst_done_id", 64'(bus.done_id), 64'd0);
    chk("post_rst_match_cnt", 64'(bus.match_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
